pw_stream_serializer: RTL and testbench

Output width converter sitting directly downstream of the DW+PW accelerator top. It accepts one wide pointwise result beat per pixel (COUT channels × DATA_W bits). It emits that beat as BEATS narrower AXI-Stream words for a DMA/interconnect, with `tlast` marking the final word of each frame and a one-cycle frame-done interrupt. It buffers exactly one pixel and sustains back-to-back pixels with no bubble cycles.

---
 rtl/pw_stream_serializer_pkg.sv | 9 +
 rtl/pw_stream_serializer.sv | 85 ++++++++
 tb/tb_pw_stream_serializer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pw_stream_serializer_pkg.sv
// rtl/pw_stream_serializer_pkg.sv - shared types for the pointwise output serializer
package pw_stream_serializer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

endpackage

// File: rtl/pw_stream_serializer.sv
// rtl/pw_stream_serializer.sv - splits one wide pixel beat into BEATS narrow stream words
module pw_stream_serializer
  import pw_stream_serializer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int COUT         = 64,
  parameter int OUT_W        = 64,
  parameter int FRAME_PIXELS = 224*224
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUT*DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   o_intr
);

  localparam int IN_W   = COUT*DATA_W;
  localparam int BEATS  = IN_W / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PIX_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_PIXELS - 1);

  state_t                       state, state_next;
  logic [BEATS-1:0][OUT_W-1:0]  hold;
  logic [BEAT_W-1:0]            beat;
  logic [PIX_W-1:0]             pix;
  logic                         full, last_beat, pixel_done, frame_done, in_hs;

  assign full       = (state == SEND);
  assign last_beat  = (beat == BEAT_LAST);
  // Last word leaving frees the hold register in the same cycle, so a new pixel can load without a bubble.
  assign pixel_done = full & m_axis_tready & last_beat;
  assign frame_done = pixel_done & (pix == PIX_LAST);
  assign in_hs      = s_axis_tvalid & s_axis_tready;

  assign s_axis_tready = !full | pixel_done;
  assign m_axis_tvalid = full;
  assign m_axis_tlast  = full & last_beat & (pix == PIX_LAST);

  generate
    if (BEATS == 1) begin : g_single
      assign m_axis_tdata = hold[0];
    end else begin : g_multi
      assign m_axis_tdata = hold[beat];
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (s_axis_tvalid) state_next = SEND;
      SEND:    if (pixel_done && !s_axis_tvalid) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      hold   <= '0;
      beat   <= '0;
      pix    <= '0;
      o_intr <= 1'b0;
    end else begin
      state  <= state_next;
      o_intr <= frame_done;
      if (in_hs) begin
        hold <= s_axis_tdata;
        beat <= '0;
      end else if (full && m_axis_tready) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
      if (pixel_done) begin
        pix <= frame_done ? '0 : pix + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pw_stream_serializer.sv
// tb/tb_pw_stream_serializer.sv - scoreboard bench for the pointwise output serializer
module tb_pw_stream_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] a_s_tdata = '0;
  logic        a_s_tvalid = 1'b0;
  logic        a_s_tready;
  logic [7:0]  a_m_tdata;
  logic        a_m_tvalid;
  logic        a_m_tready = 1'b1;
  logic        a_m_tlast;
  logic        a_intr;

  logic [31:0] b_s_tdata = '0;
  logic        b_s_tvalid = 1'b0;
  logic        b_s_tready;
  logic [31:0] b_m_tdata;
  logic        b_m_tvalid;
  logic        b_m_tready = 1'b1;
  logic        b_m_tlast;
  logic        b_intr;

  always #5 clk = ~clk;

  pw_stream_serializer #(.DATA_W(8), .COUT(4), .OUT_W(8), .FRAME_PIXELS(3)) dut_a (
    .clk(clk), .reset(reset),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .m_axis_tlast(a_m_tlast), .o_intr(a_intr)
  );

  pw_stream_serializer #(.DATA_W(8), .COUT(4), .OUT_W(32), .FRAME_PIXELS(3)) dut_b (
    .clk(clk), .reset(reset),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .m_axis_tlast(b_m_tlast), .o_intr(b_intr)
  );

  int    checks = 0;
  int    errors = 0;
  word_t sb[$];
  int    pix_model = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  int    words_seen = 0;
  int    last_count = 0;
  int    intr_count = 0;
  int    hs_cyc[$];
  bit    exp_intr = 1'b0;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic  prev_last = 1'b0;
  int    rdy_mode = 0;
  int    rdy_phase = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) a_m_tready = 1'b1;
    else begin
      a_m_tready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
      rdy_phase++;
    end
  end

  always @(negedge clk) begin
    word_t w;
    if (mon_en) begin
      check("intr", a_intr, exp_intr);
      if (a_intr) intr_count++;
      exp_intr = 1'b0;
      if (prev_stall) begin
        check("stall_valid", a_m_tvalid, 1);
        check("stall_data", a_m_tdata, prev_data);
        check("stall_last", a_m_tlast, prev_last);
      end
      if (sb.size() > 0) check("valid_pending", a_m_tvalid, 1);
      if (a_m_tvalid && a_m_tready) begin
        if (sb.size() == 0) check("unexpected_word", 1, 0);
        else begin
          w = sb.pop_front();
          check("data", a_m_tdata, w.data);
          check("last", a_m_tlast, w.last);
          exp_intr = w.last;
          if (w.last) last_count++;
          words_seen++;
          hs_cyc.push_back(cyc);
        end
      end
      prev_stall = a_m_tvalid && !a_m_tready;
      prev_data  = a_m_tdata;
      prev_last  = a_m_tlast;
    end
  end

  task automatic send_pixel(input logic [31:0] d);
    bit acc = 1'b0;
    a_s_tdata  = d;
    a_s_tvalid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = a_s_tready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("in_accept_timeout", 0, 1);
    else begin
      for (int w = 0; w < 4; w++) sb.push_back('{d[8*w +: 8], (pix_model == 2) && (w == 3)});
      pix_model = (pix_model + 1) % 3;
    end
    a_s_tvalid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 1000 && words_seen < n; i++) @(negedge clk);
    check("words_reached", words_seen, n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    sb.delete();
    pix_model = 0; exp_intr = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    int base, lc, ic;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", a_m_tvalid, 0);
    check("rst_tlast", a_m_tlast, 0);
    check("rst_intr", a_intr, 0);
    check("rst_s_tready", a_s_tready, 1);
    check("rst_tdata", a_m_tdata, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Scenario 1: single pixel, ready held high
    send_pixel(32'h44332211);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] px = 32'h44332211;
      @(negedge clk);
      check("s1_valid", a_m_tvalid, 1);
      check("s1_data", a_m_tdata, px[8*i +: 8]);
      check("s1_s_tready", a_s_tready, (i == 3) ? 1 : 0);
      check("s1_last", a_m_tlast, 0);
    end
    @(negedge clk);
    check("s1_idle", a_m_tvalid, 0);

    // Scenario 2: three back-to-back pixels
    do_reset();
    base = words_seen; lc = last_count; ic = intr_count;
    for (int p = 0; p < 3; p++) send_pixel(32'h0D0C0B0A + p * 32'h10101010);
    wait_words(base + 12);
    repeat (3) @(negedge clk);
    check("s2_span", hs_cyc[base + 11] - hs_cyc[base], 11);
    check("s2_lasts", last_count - lc, 1);
    check("s2_intrs", intr_count - ic, 1);

    // Scenario 3: same stream under 1,0,0,1 backpressure
    do_reset();
    rdy_mode = 1;
    base = words_seen; lc = last_count; ic = intr_count;
    for (int p = 0; p < 3; p++) send_pixel(32'h0D0C0B0A + p * 32'h10101010);
    wait_words(base + 12);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    check("s3_lasts", last_count - lc, 1);
    check("s3_intrs", intr_count - ic, 1);

    // Scenario 4: two frames without gaps
    do_reset();
    base = words_seen; lc = last_count; ic = intr_count;
    for (int p = 0; p < 6; p++) send_pixel(32'h80706050 ^ (p * 32'h01030507));
    wait_words(base + 24);
    repeat (3) @(negedge clk);
    check("s4_span", hs_cyc[base + 23] - hs_cyc[base], 23);
    check("s4_frame_gap", hs_cyc[base + 12] - hs_cyc[base + 11], 1);
    check("s4_lasts", last_count - lc, 2);
    check("s4_intrs", intr_count - ic, 2);

    // Scenario 5: reset in the middle of pixel 1
    do_reset();
    base = words_seen;
    send_pixel(32'hA3A2A1A0);
    send_pixel(32'hB3B2B1B0);
    wait_words(base + 7);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("s5_tvalid", a_m_tvalid, 0);
    check("s5_tlast", a_m_tlast, 0);
    check("s5_intr", a_intr, 0);
    check("s5_s_tready", a_s_tready, 1);
    check("s5_tdata", a_m_tdata, 0);
    sb.delete();
    pix_model = 0; exp_intr = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    base = words_seen; lc = last_count; ic = intr_count;
    for (int p = 0; p < 3; p++) send_pixel(32'hC3C2C1C0 + p);
    wait_words(base + 12);
    repeat (3) @(negedge clk);
    check("s5_lasts", last_count - lc, 1);
    check("s5_intrs", intr_count - ic, 1);
    check("s5_queue_empty", sb.size(), 0);

    // Scenario 6: BEATS=1 instance, one pixel per cycle
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      b_s_tvalid = (i < 3);
      b_s_tdata  = 32'h5A000000 + i;
      @(negedge clk);
      check("s6_s_tready", b_s_tready, 1);
      check("s6_intr_low", b_intr, 0);
      if (i > 0) begin
        check("s6_valid", b_m_tvalid, 1);
        check("s6_data", b_m_tdata, 32'h5A000000 + i - 1);
        check("s6_last", b_m_tlast, (i == 3) ? 1 : 0);
      end
      @(posedge clk);
      #1;
    end
    b_s_tvalid = 1'b0;
    @(negedge clk);
    check("s6_intr", b_intr, 1);
    check("s6_idle", b_m_tvalid, 0);
    @(negedge clk);
    check("s6_intr_once", b_intr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
